// File: rtl/controle_pkg.sv
// -----------------------------------------------------------------------------
// controle_pkg
// Shared definitions for the multicycle RISC-V control unit:
//   - estado_t : FSM state encoding, also driven onto the `estado` bus that
//                the instruction decoder watches
//   - OP_*     : the five opcodes this datapath executes
//   - TIPO_*   : format codes produced by the decoder
//   - ULA_*    : ALU operation selects
//   - tipo_confere : checks that a decoded format agrees with the opcode
// -----------------------------------------------------------------------------
package controle_pkg;

  typedef enum logic [3:0] {
    BUSCA      = 4'b0000,
    DECODIFICA = 4'b0001,
    EXECUTA    = 4'b0010,
    MEMORIA    = 4'b0011,
    ESCRITA    = 4'b0100,
    ERRO       = 4'b1111
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] TIPO_LOAD   = 3'b000;
  localparam logic [2:0] TIPO_IMM    = 3'b001;
  localparam logic [2:0] TIPO_STORE  = 3'b010;
  localparam logic [2:0] TIPO_R      = 3'b011;
  localparam logic [2:0] TIPO_BRANCH = 3'b110;

  localparam logic [1:0] ULA_SOMA  = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  // An opcode is only executed when the decoder agrees on its format; any
  // unknown opcode or any opcode/format disagreement is treated as illegal.
  function automatic logic tipo_confere(input logic [6:0] op, input logic [2:0] tp);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LOAD:   ok = (tp == TIPO_LOAD);
      OP_IMM:    ok = (tp == TIPO_IMM);
      OP_STORE:  ok = (tp == TIPO_STORE);
      OP_R:      ok = (tp == TIPO_R);
      OP_BRANCH: ok = (tp == TIPO_BRANCH);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/temporizador_memoria.sv
// -----------------------------------------------------------------------------
// temporizador_memoria
// Wait counter used while the control unit waits for the memory to answer.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   limpa       : clear the count (state entry, or not waiting)
//   conta       : a memory request is outstanding this cycle
//   pronto      : memory completion for this cycle
//   estourou    : this is the LIMITE-th waiting cycle and the memory is still
//                 silent; the FSM must trap at the next edge
// -----------------------------------------------------------------------------
module temporizador_memoria #(
  parameter int LIMITE = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  input  logic pronto,
  output logic estourou
);

  localparam logic [7:0] LIMITE_M1 = 8'(LIMITE - 1);
  localparam logic [7:0] UM        = 8'd1;

  logic [7:0] cont_q;
  logic [7:0] cont_d;

  // Count the cycles spent waiting; a cycle with pronto=1 is not a wait.
  always_comb begin
    cont_d = cont_q;
    if (limpa) begin
      cont_d = '0;
    end else if (conta && !pronto) begin
      cont_d = cont_q + UM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  // A completion arriving on the limit cycle wins, hence the !pronto term.
  assign estourou = conta && !pronto && (cont_q == LIMITE_M1);

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// unidade_controle_multiciclo
// Multicycle control FSM for the single-memory RISC-V datapath:
// BUSCA -> DECODIFICA -> EXECUTA -> (MEMORIA) -> (ESCRITA) -> BUSCA, with a
// sticky ERRO state for illegal instructions and memory timeouts.
//
// Parameters:
//   LARGURA_CONT : width of the retired-instruction and cycle counters
//   TIMEOUT_MEM  : wait cycles tolerated on mem_pronto before trapping (1..255)
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   habilita            : run enable, only looked at in BUSCA
//   opcode, tipo        : instruction opcode and decoder format code
//   condicao            : branch comparison result (EXECUTA)
//   mem_pronto          : memory completion
//   estado              : registered FSM state
//   pc_escreve/pc_fonte : PC load strobe and source (0 PC+4, 1 branch target)
//   ir_escreve          : IR load strobe
//   mem_le/mem_escreve  : memory read/write requests
//   reg_escreve/reg_fonte : register write strobe and source (1 = memory data)
//   ula_op              : ALU operation select
//   instr_concluidas    : retired-instruction count (wraps)
//   ciclos              : cycle counter, only built with CONTADOR_CICLOS_EN;
//                         otherwise tied to zero
//   erro                : sticky trap flag
//
// Build option: define CONTADOR_CICLOS_EN to include the cycle counter.
// -----------------------------------------------------------------------------
module unidade_controle_multiciclo
  import controle_pkg::*;
#(
  parameter int LARGURA_CONT = 32,
  parameter int TIMEOUT_MEM  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    habilita,
  input  logic [6:0]              opcode,
  input  logic [2:0]              tipo,
  input  logic                    condicao,
  input  logic                    mem_pronto,
  output logic [3:0]              estado,
  output logic                    pc_escreve,
  output logic                    pc_fonte,
  output logic                    ir_escreve,
  output logic                    mem_le,
  output logic                    mem_escreve,
  output logic                    reg_escreve,
  output logic                    reg_fonte,
  output logic [1:0]              ula_op,
  output logic [LARGURA_CONT-1:0] instr_concluidas,
  output logic [LARGURA_CONT-1:0] ciclos,
  output logic                    erro
);

  localparam logic [LARGURA_CONT-1:0] UM = LARGURA_CONT'(1);

  estado_t estado_q;
  estado_t estado_d;

  logic [LARGURA_CONT-1:0] instr_q;
  logic                    erro_q;
  logic                    eh_load_q;

  logic       pc_escreve_c;
  logic       pc_fonte_c;
  logic       ir_escreve_c;
  logic       mem_le_c;
  logic       mem_escreve_c;
  logic       reg_escreve_c;
  logic       reg_fonte_c;
  logic [1:0] ula_op_c;
  logic       retira;
  logic       aguarda;
  logic       estourou;

  // The wait counter restarts whenever the state changes or no memory
  // request is outstanding, so each BUSCA/MEMORIA visit gets a fresh budget.
  temporizador_memoria #(
    .LIMITE (TIMEOUT_MEM)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .limpa    ((estado_d != estado_q) || !aguarda),
    .conta    (aguarda),
    .pronto   (mem_pronto),
    .estourou (estourou)
  );

  // Next state and the raw strobes, decoded from the current state and
  // inputs. `retira` marks the edges that finish an instruction.
  always_comb begin
    estado_d      = estado_q;
    pc_escreve_c  = 1'b0;
    pc_fonte_c    = 1'b0;
    ir_escreve_c  = 1'b0;
    mem_le_c      = 1'b0;
    mem_escreve_c = 1'b0;
    reg_escreve_c = 1'b0;
    reg_fonte_c   = 1'b0;
    ula_op_c      = ULA_SOMA;
    retira        = 1'b0;
    aguarda       = 1'b0;

    case (estado_q)
      BUSCA: begin
        if (habilita) begin
          mem_le_c = 1'b1;
          aguarda  = 1'b1;
          if (mem_pronto) begin
            ir_escreve_c = 1'b1;
            pc_escreve_c = 1'b1;
            estado_d     = DECODIFICA;
          end else if (estourou) begin
            estado_d = ERRO;
          end
        end
      end

      DECODIFICA: begin
        estado_d = EXECUTA;
      end

      EXECUTA: begin
        if (!tipo_confere(opcode, tipo)) begin
          estado_d = ERRO;
        end else begin
          case (tipo)
            TIPO_LOAD, TIPO_STORE: begin
              ula_op_c = ULA_SOMA;
              estado_d = MEMORIA;
            end
            TIPO_IMM, TIPO_R: begin
              ula_op_c = ULA_FUNCT;
              estado_d = ESCRITA;
            end
            TIPO_BRANCH: begin
              ula_op_c = ULA_SUB;
              if (condicao) begin
                pc_escreve_c = 1'b1;
                pc_fonte_c   = 1'b1;
              end
              estado_d = BUSCA;
              retira   = 1'b1;
            end
            default: begin
              estado_d = ERRO;
            end
          endcase
        end
      end

      MEMORIA: begin
        aguarda       = 1'b1;
        mem_le_c      = eh_load_q;
        mem_escreve_c = !eh_load_q;
        if (mem_pronto) begin
          if (eh_load_q) begin
            estado_d = ESCRITA;
          end else begin
            estado_d = BUSCA;
            retira   = 1'b1;
          end
        end else if (estourou) begin
          estado_d = ERRO;
        end
      end

      ESCRITA: begin
        reg_escreve_c = 1'b1;
        reg_fonte_c   = eh_load_q;
        estado_d      = BUSCA;
        retira        = 1'b1;
      end

      ERRO: begin
        estado_d = ERRO;
      end

      default: begin
        estado_d = ERRO;
      end
    endcase
  end

  // Strobes are combinational, so they are gated with reset to guarantee
  // nothing reaches the datapath while reset is held mid-instruction.
  always_comb begin
    pc_escreve  = pc_escreve_c  && !reset;
    pc_fonte    = pc_fonte_c    && !reset;
    ir_escreve  = ir_escreve_c  && !reset;
    mem_le      = mem_le_c      && !reset;
    mem_escreve = mem_escreve_c && !reset;
    reg_escreve = reg_escreve_c && !reset;
    reg_fonte   = reg_fonte_c   && !reset;
    ula_op      = reset ? 2'b00 : ula_op_c;
  end

  // State, retired count and trap flag. The load/store choice is captured in
  // EXECUTA so MEMORIA and ESCRITA do not depend on the decoder holding tipo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= BUSCA;
      instr_q   <= '0;
      erro_q    <= 1'b0;
      eh_load_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      if (retira) begin
        instr_q <= instr_q + UM;
      end
      if (estado_d == ERRO) begin
        erro_q <= 1'b1;
      end
      if (estado_q == EXECUTA) begin
        eh_load_q <= (tipo == TIPO_LOAD);
      end
    end
  end

  assign estado           = estado_q;
  assign instr_concluidas = instr_q;
  assign erro             = erro_q;

`ifdef CONTADOR_CICLOS_EN
  logic [LARGURA_CONT-1:0] ciclos_q;

  // Cycles are counted while the machine is running: enabled in BUSCA, or
  // anywhere past BUSCA with an instruction in flight. ERRO freezes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ciclos_q <= '0;
    end else if ((estado_q != ERRO) && (habilita || (estado_q != BUSCA))) begin
      ciclos_q <= ciclos_q + UM;
    end
  end

  assign ciclos = ciclos_q;
`else
  assign ciclos = '0;
`endif

endmodule
